// File: rtl/serial_sub_pkg.sv
// Shared constants and types for the bit-serial subtractor family.
package serial_sub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned CNT_W         = $clog2(WIDTH_DEFAULT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_sub1.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_sub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock, start/busy/done handshake.
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             Bout
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bout;

    full_sub1 u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = {cell_d, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_bout;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the completed result directly from res_d.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_d;
                    bout_d  = cell_bout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed bench for serial_sub8 with hand-computed expected results.
module tb_serial_sub8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       Bout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
    endtask

    // Steps through one operation already presented by launch(). inject > 0
    // pulses start with junk operands after that many run cycles. When chain
    // is set the next operation is launched in the done cycle.
    task automatic finish_op(input string tag, input logic [7:0] ed, input logic eb,
                             input logic [7:0] pd, input logic pb, input int inject,
                             input bit chain, input logic [7:0] ca, input logic [7:0] cb,
                             input logic cbin);
        step();
        start = 1'b0;
        A     = 8'hA5;
        B     = 8'h5A;
        Bin   = 1'b1;
        chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
        chk({tag, "_accept_done"}, 32'(done), 32'd0);
        chk({tag, "_accept_diff"}, 32'(diff), 32'(pd));
        for (int i = 1; i < 8; i++) begin
            if (inject != 0 && i == inject) begin
                start = 1'b1;
                A     = 8'h10;
                B     = 8'h20;
            end
            step();
            start = 1'b0;
            chk({tag, "_run_busy"}, 32'(busy), 32'd1);
            chk({tag, "_run_done"}, 32'(done), 32'd0);
            chk({tag, "_run_diff"}, 32'(diff), 32'(pd));
            chk({tag, "_run_bout"}, 32'(Bout), 32'(pb));
        end
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(Bout), 32'(eb));
        if (chain) begin
            launch(ca, cb, cbin);
        end else begin
            step();
            chk({tag, "_post_done"}, 32'(done), 32'd0);
            chk({tag, "_post_busy"}, 32'(busy), 32'd0);
            chk({tag, "_post_diff"}, 32'(diff), 32'(ed));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        A     = 8'h51;
        B     = 8'h1E;
        Bin   = 1'b1;
        #1;
        step();
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout", 32'(Bout), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        launch(8'h51, 8'h1E, 1'b1);
        finish_op("basic", 8'h32, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'h1E, 8'h51, 1'b0);
        finish_op("under", 8'hCD, 1'b1, 8'h32, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'h00, 8'h00, 1'b1);
        finish_op("zero_bin", 8'hFF, 1'b1, 8'hCD, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'hFF, 8'hFF, 1'b0);
        finish_op("ff_ff", 8'h00, 1'b0, 8'hFF, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'h40, 8'h01, 1'b0);
        finish_op("ignore", 8'h3F, 1'b0, 8'h00, 1'b0, 3, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ignore_no_second_done", 32'(done), 32'd0);
            chk("ignore_idle_busy", 32'(busy), 32'd0);
        end

        launch(8'h0F, 8'h9E, 1'b1);
        finish_op("b2b_first", 8'h70, 1'b1, 8'h3F, 1'b0, 0, 1'b1, 8'h03, 8'h1E, 1'b1);
        finish_op("b2b_second", 8'hE4, 1'b1, 8'h70, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'h59, 8'hDE, 1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("midop_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midop_busy", 32'(busy), 32'd0);
        chk("midop_done", 32'(done), 32'd0);
        chk("midop_diff", 32'(diff), 32'd0);
        chk("midop_bout", 32'(Bout), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midop_no_done", 32'(done), 32'd0);
            chk("midop_idle", 32'(busy), 32'd0);
        end

        launch(8'h79, 8'h06, 1'b0);
        finish_op("after_rst", 8'h73, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed simulation still running expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
Bit-serial 8-bit subtractor; the subtract-direction counterpart of the team's combinational 8-bit adder.
- Computes A - B - Bin LSB-first, one bit per clock, through a single 1-bit full-subtractor cell.
- Uses a start/busy/done handshake.
- Sits in datapaths that trade latency for area, and serves as the golden check for adder/subtractor pairs (A + B, then subtract B back).

Parameters:
WIDTH, 8, operand and result width in bits (min 2).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
A  input  WIDTH  minuend; captured on the accepted start edge
B  input  WIDTH  subtrahend; captured on the accepted start edge
Bin  input  1  borrow-in; captured on the accepted start edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; diff/Bout updated on this edge
diff  output  WIDTH  result A - B - Bin mod 2^WIDTH; holds until the next completion
Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned)

Behaviour:
- Reset (async assert, sync-free release):
  - state=IDLE; busy=0, done=0, diff=0, Bout=0.
  - Internal shift regs, borrow flop and bit counter cleared.
- States: IDLE, RUN.
- IDLE:
  - On an edge with start=1: latch A, B into shift regs and Bin into the borrow flop; counter=0.
  - Go to RUN; busy=1 after that edge.
  - start=0: stay in IDLE.
- RUN, per edge, one bit processed:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d is shifted into the result reg at the MSB end; operand regs shift right; counter++.
- On the edge processing bit WIDTH-1:
  - diff <= full result; Bout <= br_next; done=1 for exactly that cycle.
  - busy=0; state=IDLE.
- Latency: start accepted at edge k; done high after edge k+WIDTH (8 cycles at default). busy is high for exactly WIDTH cycles.
- start while busy=1: ignored, no effect on operands or counter. A/B/Bin changes while busy are ignored.
- start=1 in the done cycle: accepted, because busy=0 in that cycle.
  - Next edge: done=0, busy=1, diff/Bout hold the previous result.
  - Back-to-back throughput is one result per WIDTH cycles.
- diff/Bout change only on completion edges or reset. No partial results are visible.
- Reset mid-operation: immediate return to the reset values. The operation is dropped and no done is issued.
- Arithmetic is unsigned modulo 2^WIDTH.
  - Signed overflow is not reported.
  - Bout is the true borrow, so {~Bout, diff} equals the WIDTH+1-bit sum A + ~B + ~Bin.

Decomposition:
- Package serial_sub_pkg:
  - WIDTH_DEFAULT=8
  - state enum {IDLE, RUN}
  - counter width constant CNT_W = $clog2(WIDTH)
- Sub-module full_sub1: combinational (a, b, bin) -> (d, bout). Instantiated once in serial_sub8; reused by future ripple variants.

Test Plan:
- Reset: assert reset for 2 cycles with start=1 held -> busy=0, done=0, diff=0x00, Bout=0; no operation starts while reset is high.
- Basic subtract: A=0x51, B=0x1E, Bin=1, start pulse -> exactly 8 cycles later done=1 for 1 cycle, diff=0x32, Bout=0; busy high for exactly 8 cycles.
- Underflow and borrow corners:
  - A=0x1E, B=0x51, Bin=0 -> diff=0xCD, Bout=1.
  - A=0x00, B=0x00, Bin=1 -> diff=0xFF, Bout=1.
  - A=0xFF, B=0xFF, Bin=0 -> diff=0x00, Bout=0.
- Ignore while busy: start A=0x40, B=0x01, Bin=0; at cycle 3 pulse start with A=0x10, B=0x20 -> single done at cycle 8 with diff=0x3F, Bout=0; no second done.
- Back-to-back: start A=0x0F, B=0x9E, Bin=1; hold start=1 in its done cycle with A=0x03, B=0x1E, Bin=1 -> first done: diff=0x70, Bout=1. Second done 8 cycles later: diff=0xE4, Bout=1. diff holds 0x70 in between.
- Reset mid-op: start A=0x59, B=0xDE; assert reset at cycle 4 -> busy, done, diff and Bout go to 0 immediately. After release, new start A=0x79, B=0x06, Bin=0 -> diff=0x73, Bout=0 after 8 cycles.
